// File: rtl/qspi_fill_arbiter_if.sv
// Bus bundle between the two line-fill requesters, the fill arbiter and the quad-I/O flash reader.
// The slave view belongs to the arbiter; the master view belongs to the requesters and flash reader side.
interface qspi_fill_arbiter_if #(
  parameter int unsigned LINE_SIZE = 128
);
  localparam int unsigned AW = 24;

  logic                 req0;
  logic                 req1;
  logic [AW-1:0]        addr0;
  logic [AW-1:0]        addr1;
  logic                 ack0;
  logic                 ack1;
  logic                 err0;
  logic                 err1;
  logic [LINE_SIZE-1:0] line;
  logic                 busy;
  logic                 fr_rd;
  logic [AW-1:0]        fr_addr;
  logic                 fr_done;
  logic [LINE_SIZE-1:0] fr_line;

  modport slave (
    input  req0, req1, addr0, addr1, fr_done, fr_line,
    output ack0, ack1, err0, err1, line, busy, fr_rd, fr_addr
  );

  modport master (
    output req0, req1, addr0, addr1, fr_done, fr_line,
    input  ack0, ack1, err0, err1, line, busy, fr_rd, fr_addr
  );
endinterface

// File: rtl/qspi_fill_arbiter.sv
// Serialises cache line fills from two requesters onto one flash reader, with round-robin
// tie-breaking, a per-fill timeout and a minimum idle gap between flash transactions.
module qspi_fill_arbiter #(
  parameter int unsigned LINE_SIZE = 128,
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned GAP       = 2
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  qspi_fill_arbiter_if.slave  bus
);
  localparam int unsigned AW = 24;
  localparam int unsigned TW = 8;
  localparam int unsigned GW = 4;

  localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT);
  localparam logic [GW-1:0] GAP_LOAD   = (GAP > 0) ? GW'(GAP - 1) : GW'(0);
  localparam logic [AW-1:0] LINE_MASK  = ~AW'(15);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP,
    S_GAP
  } state_t;

  state_t        state;
  logic          owner;
  logic          last_grant;
  logic [TW-1:0] timer;
  logic [GW-1:0] gap_cnt;

  logic          grant_c;
  logic          pick1_c;
  logic [AW-1:0] pick_addr_c;

  // Port 1 wins when it is the only requester, or on a tie when port 0 was served last.
  assign grant_c     = bus.req0 | bus.req1;
  assign pick1_c     = bus.req1 & (~bus.req0 | ~last_grant);
  assign pick_addr_c = pick1_c ? bus.addr1 : bus.addr0;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state       <= S_IDLE;
      owner       <= 1'b0;
      last_grant  <= 1'b1;
      timer       <= '0;
      gap_cnt     <= '0;
      bus.ack0    <= 1'b0;
      bus.ack1    <= 1'b0;
      bus.err0    <= 1'b0;
      bus.err1    <= 1'b0;
      bus.fr_rd   <= 1'b0;
      bus.busy    <= 1'b0;
      bus.fr_addr <= '0;
      bus.line    <= '0;
    end else begin
      bus.fr_rd <= 1'b0;
      bus.ack0  <= 1'b0;
      bus.ack1  <= 1'b0;
      bus.err0  <= 1'b0;
      bus.err1  <= 1'b0;

      unique case (state)
        S_IDLE: begin
          if (grant_c) begin
            owner       <= pick1_c;
            bus.fr_addr <= pick_addr_c & LINE_MASK;
            bus.fr_rd   <= 1'b1;
            bus.busy    <= 1'b1;
            state       <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          timer <= TIMER_LOAD;
          state <= S_WAIT;
        end

        // A completion in the last timer cycle still wins over the timeout.
        S_WAIT: begin
          if (bus.fr_done) begin
            bus.line <= bus.fr_line;
            bus.ack0 <= ~owner;
            bus.ack1 <= owner;
            state    <= S_RESP;
          end else if (timer == '0) begin
            bus.err0 <= ~owner;
            bus.err1 <= owner;
            state    <= S_RESP;
          end else begin
            timer <= timer - TW'(1);
          end
        end

        S_RESP: begin
          last_grant <= owner;
          if (GAP == 0) begin
            bus.busy <= 1'b0;
            state    <= S_IDLE;
          end else begin
            gap_cnt <= GAP_LOAD;
            state   <= S_GAP;
          end
        end

        S_GAP: begin
          if (gap_cnt == '0) begin
            bus.busy <= 1'b0;
            state    <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt - GW'(1);
          end
        end

        default: begin
          bus.busy <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_qspi_fill_arbiter.sv
// Directed bench for qspi_fill_arbiter: three instances cover the default, short-timeout/GAP=3
// and GAP=0 parameter sets; expected values are hand-derived cycle positions and data.
module tb_qspi_fill_arbiter;
  localparam int unsigned LS = 128;

  logic HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  logic [2:0]          rst_n;
  logic [2:0]          req0_s, req1_s, done_s;
  logic [2:0][23:0]    addr0_s, addr1_s;
  logic [2:0][LS-1:0]  fline_s;
  logic [2:0]          ack0_o, ack1_o, err0_o, err1_o, busy_o, frrd_o;
  logic [2:0][23:0]    fraddr_o;
  logic [2:0][LS-1:0]  line_o;

  qspi_fill_arbiter_if #(.LINE_SIZE(LS)) bus_v [3] ();

  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam int unsigned TO = (k == 1) ? 10 : 255;
    localparam int unsigned GP = (k == 0) ? 2 : ((k == 1) ? 3 : 0);

    assign bus_v[k].req0    = req0_s[k];
    assign bus_v[k].req1    = req1_s[k];
    assign bus_v[k].addr0   = addr0_s[k];
    assign bus_v[k].addr1   = addr1_s[k];
    assign bus_v[k].fr_done = done_s[k];
    assign bus_v[k].fr_line = fline_s[k];
    assign ack0_o[k]   = bus_v[k].ack0;
    assign ack1_o[k]   = bus_v[k].ack1;
    assign err0_o[k]   = bus_v[k].err0;
    assign err1_o[k]   = bus_v[k].err1;
    assign busy_o[k]   = bus_v[k].busy;
    assign frrd_o[k]   = bus_v[k].fr_rd;
    assign fraddr_o[k] = bus_v[k].fr_addr;
    assign line_o[k]   = bus_v[k].line;

    qspi_fill_arbiter #(.LINE_SIZE(LS), .TIMEOUT(TO), .GAP(GP)) dut (
      .HCLK    (HCLK),
      .HRESETn (rst_n[k]),
      .bus     (bus_v[k])
    );
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge HCLK);
  endtask

  // Advances until fr_rd is seen high; n is the number of cycles it took.
  task automatic wait_rd(input logic [1:0] k, input string tag, output int n);
    n = 0;
    while (frrd_o[k] !== 1'b1 && n < 400) begin
      tick(1);
      n++;
    end
    chk({tag, "_seen"}, 128'(frrd_o[k]), 128'(1));
  endtask

  // Completes one fill and checks which port is acknowledged; the winner then drops its request.
  task automatic serve(input logic [1:0] k, input logic [127:0] d, input logic exp_port, input string tag);
    int n;
    logic [23:0] ea;
    ea = (exp_port ? addr1_s[k] : addr0_s[k]) & 24'hFFFFF0;
    wait_rd(k, tag, n);
    chk({tag, "_addr"}, 128'(fraddr_o[k]), 128'(ea));
    tick(1);
    fline_s[k] = d;
    done_s[k]  = 1'b1;
    tick(1);
    done_s[k]  = 1'b0;
    chk({tag, "_ack0"}, 128'(ack0_o[k]), 128'(!exp_port));
    chk({tag, "_ack1"}, 128'(ack1_o[k]), 128'(exp_port));
    chk({tag, "_line"}, line_o[k], d);
    if (exp_port) req1_s[k] = 1'b0;
    else          req0_s[k] = 1'b0;
  endtask

  // Port 0 completes while port 1 waits; measures ack0 to the next fr_rd.
  task automatic gap_test(input logic [1:0] k, input int exp_gap, input string tag);
    int n;
    req0_s[k]  = 1'b1;
    addr0_s[k] = 24'h3456F7;
    wait_rd(k, {tag, "_rd0"}, n);
    req1_s[k]  = 1'b1;
    addr1_s[k] = 24'h2000AB;
    tick(1);
    fline_s[k] = {4{32'hC0DE_0000 + 32'(k)}};
    done_s[k]  = 1'b1;
    tick(1);
    done_s[k]  = 1'b0;
    chk({tag, "_ack0"}, 128'(ack0_o[k]), 128'(1));
    req0_s[k] = 1'b0;
    wait_rd(k, {tag, "_rd1"}, n);
    chk({tag, "_spacing"}, 128'(n), 128'(exp_gap));
    chk({tag, "_addr1"}, 128'(fraddr_o[k]), 128'(24'h2000A0));
    tick(1);
    done_s[k] = 1'b1;
    tick(1);
    done_s[k] = 1'b0;
    chk({tag, "_ack1"}, 128'(ack1_o[k]), 128'(1));
    req1_s[k] = 1'b0;
    tick(6);
  endtask

  initial begin
    int n;
    logic [127:0] la5, lc, lstray;
    la5    = {16{8'hA5}};
    lc     = {4{32'h1234_5678}};
    lstray = {4{32'hDEAD_BEEF}};

    rst_n   = '0;
    req0_s  = '0;
    req1_s  = '0;
    done_s  = '0;
    addr0_s = '0;
    addr1_s = '0;
    fline_s = '0;
    tick(2);
    chk("rst_busy",  128'(busy_o), 128'(0));
    chk("rst_fr_rd", 128'(frrd_o), 128'(0));
    chk("rst_ackerr", 128'(ack0_o | ack1_o | err0_o | err1_o), 128'(0));
    chk("rst_fraddr", 128'(fraddr_o[0]), 128'(0));
    chk("rst_line",  line_o[0], 128'(0));
    rst_n = '1;
    tick(1);

    // Single fill on the default instance
    addr0_s[0] = 24'h012345;
    req0_s[0]  = 1'b1;
    wait_rd(2'd0, "sf_rd", n);
    chk("sf_grant_lat", 128'(n), 128'(1));
    chk("sf_fraddr", 128'(fraddr_o[0]), 128'(24'h012340));
    chk("sf_busy", 128'(busy_o[0]), 128'(1));
    tick(1);
    chk("sf_rd_width", 128'(frrd_o[0]), 128'(0));
    tick(18);
    chk("sf_no_early_ack", 128'(ack0_o[0]), 128'(0));
    tick(1);
    fline_s[0] = la5;
    done_s[0]  = 1'b1;
    tick(1);
    done_s[0]  = 1'b0;
    chk("sf_ack0", 128'(ack0_o[0]), 128'(1));
    chk("sf_ack1", 128'(ack1_o[0]), 128'(0));
    chk("sf_err0", 128'(err0_o[0]), 128'(0));
    chk("sf_line", line_o[0], la5);
    req0_s[0] = 1'b0;
    tick(1);
    chk("sf_ack_width", 128'(ack0_o[0]), 128'(0));
    chk("sf_busy_gap", 128'(busy_o[0]), 128'(1));
    tick(2);
    chk("sf_busy_idle", 128'(busy_o[0]), 128'(0));

    // Tie from reset, then round-robin under both last_grant values
    rst_n[0] = 1'b0;
    tick(1);
    rst_n[0]   = 1'b1;
    addr1_s[0] = 24'h0ABCDE;
    req0_s[0]  = 1'b1;
    req1_s[0]  = 1'b1;
    serve(2'd0, {4{32'h1111_0001}}, 1'b0, "rr1");
    serve(2'd0, {4{32'h1111_0002}}, 1'b1, "rr2");
    req0_s[0] = 1'b1;
    req1_s[0] = 1'b1;
    serve(2'd0, {4{32'h1111_0003}}, 1'b0, "rr3");
    serve(2'd0, {4{32'h1111_0004}}, 1'b1, "rr4");
    req0_s[0] = 1'b1;
    serve(2'd0, {4{32'h1111_0005}}, 1'b0, "rr5");
    req0_s[0] = 1'b1;
    req1_s[0] = 1'b1;
    serve(2'd0, {4{32'h1111_0006}}, 1'b1, "rr6");
    serve(2'd0, {4{32'h1111_0007}}, 1'b0, "rr7");
    tick(4);

    // Asynchronous reset in the middle of a fill
    addr0_s[0] = 24'h00FF3C;
    req0_s[0]  = 1'b1;
    wait_rd(2'd0, "rm_rd", n);
    tick(3);
    #2 rst_n[0] = 1'b0;
    #1;
    chk("rm_busy",   128'(busy_o[0]), 128'(0));
    chk("rm_fraddr", 128'(fraddr_o[0]), 128'(0));
    chk("rm_line",   line_o[0], 128'(0));
    chk("rm_ackerr", 128'({ack0_o[0], ack1_o[0], err0_o[0], err1_o[0], frrd_o[0]}), 128'(0));
    @(negedge HCLK);
    rst_n[0] = 1'b1;
    tick(1);
    chk("rm_rd_again", 128'(frrd_o[0]), 128'(1));
    chk("rm_fraddr2", 128'(fraddr_o[0]), 128'(24'h00FF30));
    req0_s[0] = 1'b0;

    // Completion exactly when the timer reaches zero (TIMEOUT=10)
    addr0_s[1] = 24'h100007;
    req0_s[1]  = 1'b1;
    wait_rd(2'd1, "co_rd", n);
    tick(11);
    chk("co_pending", 128'({ack0_o[1], err0_o[1]}), 128'(0));
    fline_s[1] = lc;
    done_s[1]  = 1'b1;
    tick(1);
    done_s[1]  = 1'b0;
    chk("co_ack0", 128'(ack0_o[1]), 128'(1));
    chk("co_err0", 128'(err0_o[1]), 128'(0));
    chk("co_line", line_o[1], lc);
    req0_s[1] = 1'b0;
    tick(6);

    // Timeout with no completion, then a stray completion during the gap
    req0_s[1] = 1'b1;
    wait_rd(2'd1, "to_rd", n);
    tick(11);
    chk("to_early", 128'(err0_o[1]), 128'(0));
    chk("to_busy", 128'(busy_o[1]), 128'(1));
    tick(1);
    chk("to_err0", 128'(err0_o[1]), 128'(1));
    chk("to_ack0", 128'(ack0_o[1]), 128'(0));
    chk("to_line", line_o[1], lc);
    req0_s[1] = 1'b0;
    tick(1);
    fline_s[1] = lstray;
    done_s[1]  = 1'b1;
    tick(1);
    done_s[1]  = 1'b0;
    chk("stray_ack", 128'({ack0_o[1], ack1_o[1], err0_o[1]}), 128'(0));
    chk("stray_line", line_o[1], lc);
    tick(1);
    chk("to_busy_gap", 128'(busy_o[1]), 128'(1));
    tick(1);
    chk("to_busy_idle", 128'(busy_o[1]), 128'(0));

    // Minimum idle gap between transactions
    gap_test(2'd1, 5, "g3");
    gap_test(2'd2, 2, "g0");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
